// File: rtl/robm_plant_model.sv
// Robot/workcell plant emulator. It answers the controller's y1..y10 command strobes with
// x1..x12 sensor/status, models job latencies and flags disallowed command sequences.
module robm_plant_model #(
    parameter int          JOB_GAP   = 4,
    parameter int          OP_LAT    = 3,
    parameter int          XFER_LAT  = 2,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        run,
    input  logic        fix_attr,
    input  logic [8:0]  attr_in,
    input  logic        y1,
    input  logic        y2,
    input  logic        y3,
    input  logic        y4,
    input  logic        y5,
    input  logic        y6,
    input  logic        y7,
    input  logic        y8,
    input  logic        y9,
    input  logic        y10,
    output logic        x1,
    output logic        x2,
    output logic        x3,
    output logic        x4,
    output logic        x5,
    output logic        x6,
    output logic        x7,
    output logic        x8,
    output logic        x9,
    output logic        x10,
    output logic        x11,
    output logic        x12,
    output logic        busy,
    output logic        prot_err,
    output logic [15:0] job_cnt
);

    typedef enum logic [3:0] {
        P_IDLE, P_REQ, P_PROC, P_OPER, P_DONE, P_XFER, P_XDONE, P_INSP, P_EVAL, P_RET
    } state_t;

    typedef enum logic [3:0] {
        C_NONE, C_OP, C_XF, C_IN, C_EV, C_RT, C_FN, C_PR, C_ILL
    } cmd_t;

    localparam logic [15:0] SEED     = (LFSR_SEED == 16'h0000) ? 16'hACE1 : LFSR_SEED;
    localparam logic [7:0]  GAP_LAST = 8'(JOB_GAP - 1);
    localparam logic [7:0]  OP_LAST  = 8'(OP_LAT - 1);
    localparam logic [7:0]  XF_LAST  = 8'(XFER_LAT - 1);

    state_t      state, state_nxt;
    cmd_t        cmd;
    logic        cmd_err;
    logic        job_done;
    logic [7:0]  cnt;
    logic [8:0]  attr;
    logic [15:0] lfsr;
    logic [9:0]  y_vec;

    assign y_vec = {y10, y9, y8, y7, y6, y5, y4, y3, y2, y1};

    // Decode is prioritised so every vector maps to exactly one command class.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        cmd = C_ILL;
        if (y_vec == 10'b0)                 cmd = C_NONE;
        else if (y2 & (y1 ^ y3) & ~y9)      cmd = C_OP;
        else if (y2 & y9)                   cmd = C_XF;
        else if (y7 & y8)                   cmd = C_IN;
        else if (y6)                        cmd = C_EV;
        else if (y4)                        cmd = C_RT;
        else if (y5)                        cmd = C_FN;
        else if (y10)                       cmd = C_PR;
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
        if (!rst) state <= P_IDLE;
        else      state <= state_nxt;
    end

    // Next-state logic; any command not accepted by the current state aborts the job.
    always_comb begin
        state_nxt = state;
        cmd_err   = 1'b0;
        unique case (state)
            P_IDLE:  if (cmd != C_NONE) cmd_err = 1'b1;
                     else if (run && cnt == GAP_LAST) state_nxt = P_REQ;
            P_REQ:   case (cmd)
                         C_OP:    state_nxt = P_OPER;
                         C_RT:    state_nxt = P_RET;
                         C_IN:    state_nxt = P_INSP;
                         C_PR:    state_nxt = P_PROC;
                         C_NONE:  ;
                         default: cmd_err = 1'b1;
                     endcase
            P_PROC:  case (cmd)
                         C_XF:    state_nxt = P_XFER;
                         C_OP:    state_nxt = P_OPER;
                         C_NONE:  ;
                         default: cmd_err = 1'b1;
                     endcase
            P_OPER:  if (cmd != C_NONE) cmd_err = 1'b1;
                     else if (cnt == OP_LAST) state_nxt = P_DONE;
            P_DONE:  if (cmd == C_RT) state_nxt = P_RET;
                     else if (cmd != C_NONE) cmd_err = 1'b1;
            P_XFER:  if (cmd != C_NONE) cmd_err = 1'b1;
                     else if (cnt == XF_LAST) state_nxt = P_XDONE;
            P_XDONE: if (cmd == C_OP) state_nxt = P_OPER;
                     else if (cmd != C_NONE) cmd_err = 1'b1;
            P_INSP:  if (cmd == C_EV) state_nxt = P_EVAL;
                     else if (cmd != C_NONE) cmd_err = 1'b1;
            P_EVAL:  case (cmd)
                         C_OP:    state_nxt = P_OPER;
                         C_RT:    state_nxt = P_RET;
                         C_NONE:  ;
                         default: cmd_err = 1'b1;
                     endcase
            P_RET:   if (cmd == C_FN) state_nxt = P_IDLE;
                     else if (cmd != C_NONE) cmd_err = 1'b1;
            default: state_nxt = P_IDLE;
        endcase
        if (cmd_err) state_nxt = P_IDLE;
    end

    assign job_done = (state == P_RET) && (cmd == C_FN);

    // Datapath: shared gap/latency counter, attribute latch, LFSR and status counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt      <= 8'd0;
            attr     <= 9'd0;
            lfsr     <= SEED;
            prot_err <= 1'b0;
            job_cnt  <= 16'd0;
        end else begin
            lfsr <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
            if (cmd_err)  prot_err <= 1'b1;
            if (job_done) job_cnt  <= job_cnt + 16'd1;
            if (state == P_IDLE && state_nxt == P_REQ)
                attr <= fix_attr ? attr_in : lfsr[8:0];
            if (state_nxt != state || cmd_err)
                cnt <= 8'd0;
            else if ((state == P_IDLE && run) || state == P_OPER || state == P_XFER)
                cnt <= cnt + 8'd1;
        end
    end

    // Output decode.
    always_comb begin
        busy = (state != P_IDLE);
        x1   = (state == P_REQ);
        x4   = (state == P_DONE);
        x7   = (state == P_XDONE);
        {x12, x11, x10, x9, x8, x6, x5, x3, x2} = busy ? attr : 9'd0;
    end

endmodule

// File: tb/tb_robm_plant_model.sv
// Directed-plus-random bench for robm_plant_model: a job-level controller drives legal and
// illegal command sequences and checks timing, attributes and counters against rule-derived values.
module tb_robm_plant_model;

    localparam int          JOB_GAP  = 4;
    localparam int          OP_LAT   = 3;
    localparam int          XFER_LAT = 2;
    localparam logic [15:0] SEED     = 16'hACE1;

    localparam logic [9:0] Y1 = 10'h001, Y2 = 10'h002, Y3 = 10'h004, Y4 = 10'h008, Y5 = 10'h010;
    localparam logic [9:0] Y6 = 10'h020, Y7 = 10'h040, Y8 = 10'h080, Y9 = 10'h100, Y10 = 10'h200;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        run = 1'b0;
    logic        fix_attr = 1'b0;
    logic [8:0]  attr_in = 9'd0;
    logic [9:0]  yv = 10'd0;
    logic        x1, x2, x3, x4, x5, x6, x7, x8, x9, x10, x11, x12;
    logic        busy, prot_err;
    logic [15:0] job_cnt;

    int          n_vec = 0;
    int          n_err = 0;
    int          edges = 0;
    int          exp_jobs = 0;
    logic [8:0]  exp_attr;

    wire [11:0] x_all    = {x12, x11, x10, x9, x8, x7, x6, x5, x4, x3, x2, x1};
    wire [8:0]  attr_obs = {x12, x11, x10, x9, x8, x6, x5, x3, x2};

    robm_plant_model #(
        .JOB_GAP(JOB_GAP), .OP_LAT(OP_LAT), .XFER_LAT(XFER_LAT), .LFSR_SEED(SEED)
    ) dut (
        .clk(clk), .rst(rst), .run(run), .fix_attr(fix_attr), .attr_in(attr_in),
        .y1(yv[0]), .y2(yv[1]), .y3(yv[2]), .y4(yv[3]), .y5(yv[4]),
        .y6(yv[5]), .y7(yv[6]), .y8(yv[7]), .y9(yv[8]), .y10(yv[9]),
        .x1(x1), .x2(x2), .x3(x3), .x4(x4), .x5(x5), .x6(x6),
        .x7(x7), .x8(x8), .x9(x9), .x10(x10), .x11(x11), .x12(x12),
        .busy(busy), .prot_err(prot_err), .job_cnt(job_cnt)
    );

    always #5 clk = ~clk;

    // Rising edges seen out of reset; the LFSR has advanced once per such edge.
    always @(posedge clk) begin
        if (!rst) edges <= 0;
        else      edges <= edges + 1;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    // Reference LFSR: x^16+x^14+x^13+x^11+1 in its shift-right Fibonacci form.
    function automatic logic [15:0] lfsr_after(input int n);
        int v, b;
        v = int'(SEED);
        for (int i = 0; i < n; i++) begin
            b = ((v >> 0) ^ (v >> 2) ^ (v >> 3) ^ (v >> 5)) & 1;
            v = (v >> 1) | (b << 15);
        end
        return 16'(v);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic cmd(input logic [9:0] v);
        yv = v;
        step();
        yv = 10'd0;
    endtask

    task automatic nones(input int n);
        yv = 10'd0;
        repeat (n) step();
        check("stay_busy", busy, 1);
    endtask

    // Wait out the idle gap (optionally with run low first) and check x1 timing and attributes.
    task automatic wait_req(input int pause);
        int         n;
        logic [15:0] l;
        n = 0;
        run = 1'b0;
        repeat (pause) step();
        check("gap_hold", {x1, busy}, 0);
        run = 1'b1;
        while (!x1 && n < 300) begin
            step();
            n++;
        end
        check("gap_len", n, JOB_GAP);
        l = lfsr_after(edges - 1);
        exp_attr = fix_attr ? attr_in : l[8:0];
        check("req_attr", attr_obs, exp_attr);
        check("req_flags", {x1, x4, x7, busy}, 4'b1001);
    endtask

    task automatic do_op();
        cmd(($urandom_range(0, 1) != 0) ? (Y1 | Y2) : (Y2 | Y3));
        check("op_acc", {x1, x4, x7, busy}, 4'b0001);
        repeat (OP_LAT - 1) begin
            step();
            check("x4_early", x4, 0);
        end
        step();
        check("x4_rise", {x4, busy}, 2'b11);
    endtask

    task automatic do_xfer();
        cmd(Y2 | Y9);
        check("xf_acc", {x1, x4, x7, busy}, 4'b0001);
        repeat (XFER_LAT - 1) begin
            step();
            check("x7_early", x7, 0);
        end
        step();
        check("x7_rise", {x7, busy}, 2'b11);
    endtask

    task automatic finish_job();
        cmd(Y4);
        check("ret_flags", {x1, x4, x7, busy}, 4'b0001);
        check("attr_hold", attr_obs, exp_attr);
        cmd(Y5);
        exp_jobs++;
        check("fn_idle", {busy, x_all}, 0);
        check("job_cnt", job_cnt, exp_jobs);
    endtask

    task automatic random_job(input int kind);
        case (kind)
            0: begin nones($urandom_range(0, 2)); finish_job(); end
            1: begin do_op(); nones($urandom_range(0, 2)); finish_job(); end
            2: begin
                cmd(Y10); nones($urandom_range(0, 2));
                do_xfer(); nones($urandom_range(0, 2));
                do_op(); finish_job();
            end
            3: begin cmd(Y10); nones($urandom_range(0, 2)); do_op(); finish_job(); end
            default: begin
                cmd(Y7 | Y8); nones($urandom_range(0, 2));
                cmd(Y6); nones($urandom_range(0, 2));
                if ($urandom_range(0, 1) != 0) do_op();
                finish_job();
            end
        endcase
    endtask

    initial begin
        // Reset with command noise: everything quiet.
        repeat (3) begin
            yv = 10'($urandom);
            step();
        end
        check("rst_outs", {x_all, busy, prot_err}, 0);
        check("rst_jobs", job_cnt, 0);
        yv = 10'd0;
        rst = 1'b1;
        wait_req(0);
        finish_job();

        // Forced attributes, return-only job.
        fix_attr = 1'b1;
        attr_in  = 9'b110000000;
        wait_req(0);
        finish_job();

        // Operation path.
        attr_in = 9'b100010000;
        wait_req(0);
        do_op();
        finish_job();
        check("x4_clear", x4, 0);

        // Process, transfer, operation path.
        attr_in = 9'b100001000;
        wait_req(0);
        cmd(Y10);
        check("proc_flags", {x1, busy}, 2'b01);
        do_xfer();
        do_op();
        finish_job();

        // Protocol errors: idle, request, operation and process states.
        cmd(Y5);
        check("err_idle", {prot_err, busy}, 2'b10);
        check("err_idle_jobs", job_cnt, exp_jobs);
        attr_in = 9'($urandom);
        wait_req(2);
        random_job(int'($urandom_range(0, 4)));
        check("err_sticky", prot_err, 1);
        wait_req(0);
        cmd(Y6);
        check("err_req", {prot_err, busy, x1}, 3'b100);
        wait_req(0);
        cmd(Y1 | Y2);
        cmd(Y4);
        check("err_oper", {prot_err, busy, x4}, 3'b100);
        wait_req(0);
        cmd(Y10);
        cmd(Y3);
        check("err_illegal", {prot_err, busy}, 2'b10);
        check("err_jobs", job_cnt, exp_jobs);
        rst = 1'b0;
        #1;
        check("err_rst", {prot_err, job_cnt}, 0);
        exp_jobs = 0;
        step();
        rst = 1'b1;

        // Reset one cycle before x4 discards the job.
        wait_req(0);
        cmd(Y1 | Y2);
        repeat (OP_LAT - 1) step();
        check("pre_x4", {x4, busy}, 2'b01);
        rst = 1'b0;
        repeat (2) begin
            step();
            check("rst_no_x4", {x4, busy, job_cnt}, 0);
        end
        rst = 1'b1;

        // Loopback: 32 random jobs with LFSR attributes.
        fix_attr = 1'b0;
        for (int j = 0; j < 32; j++) begin
            wait_req(int'($urandom_range(0, 3)));
            random_job(int'($urandom_range(0, 4)));
        end
        check("loop_jobs", job_cnt, 32);
        check("loop_err", prot_err, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
